// File: rtl/instruction_fetch_unit.sv
// Fetch stage: prefetch queue between instruction memory and decode.
// Define BRANCH_PREDICT_EN to predict backward conditional branches as taken.
module instruction_fetch_unit #(
   parameter int unsigned FIFO_DEPTH    = 4,
   parameter logic [31:0] RESET_ADDRESS = 32'h0000_0000
) (
   input  logic        clock_i,
   input  logic        reset_n_i,
   output logic        imem_request_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] restart_address_i,
   output logic [31:0] instruction_o,
   output logic [31:0] pc_o,
   output logic        branch_predicted_o
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        pred;
   } entry_t;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

   state_t           state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      saved_pc_q, saved_pc_d;
   logic             req_q;
   entry_t           fifo_q [FIFO_DEPTH];
   entry_t           head_c;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             push_c, pop_c, room_after_push_c;
   logic [31:0]      seq_pc_c, next_pc_c;
   logic             taken_c;

   assign seq_pc_c = fetch_pc_q + 32'd4;

`ifdef BRANCH_PREDICT_EN
   assign taken_c   = (imem_data_i[31:27] == 5'b11000) && imem_data_i[15];
   assign next_pc_c = taken_c ? (seq_pc_c + {{16{imem_data_i[15]}}, imem_data_i[15:0]})
                              : seq_pc_c;
`else
   assign taken_c   = 1'b0;
   assign next_pc_c = seq_pc_c;
`endif

   assign pop_c             = !flush_i && !stall_i && (count_q != '0);
   assign room_after_push_c = (count_q + CNT_W'(1) - CNT_W'(pop_c)) < DEPTH_C;
   assign head_c            = fifo_q[rd_ptr_q];

   assign imem_request_o = req_q;
   assign imem_addr_o    = fetch_pc_q;

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_ADDRESS;
         saved_pc_q <= RESET_ADDRESS;
         req_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         saved_pc_q <= saved_pc_d;
         req_q      <= (state_d != S_IDLE);
      end
   end

   // Fetch FSM: a flushed request must still complete before the redirect is issued
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      saved_pc_d = saved_pc_q;
      push_c     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (flush_i)                fetch_pc_d = restart_address_i;
            else if (count_q < DEPTH_C) state_d    = S_WAIT;
         end
         S_WAIT: begin
            if (flush_i) begin
               if (imem_ack_i) begin
                  fetch_pc_d = restart_address_i;
                  state_d    = S_IDLE;
               end else begin
                  saved_pc_d = restart_address_i;
                  state_d    = S_DISCARD;
               end
            end else if (imem_ack_i) begin
               push_c     = 1'b1;
               fetch_pc_d = next_pc_c;
               if (!room_after_push_c) state_d = S_IDLE;
            end
         end
         S_DISCARD: begin
            if (flush_i) saved_pc_d = restart_address_i;
            if (imem_ack_i) begin
               fetch_pc_d = flush_i ? restart_address_i : saved_pc_q;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      end
   end

   always_ff @(posedge clock_i) begin
      if (push_c) fifo_q[wr_ptr_q] <= '{instr: imem_data_i, pc: seq_pc_c, pred: taken_c};
   end

   // Decode-facing register; an empty queue presents a NOP with pc held
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         instruction_o      <= '0;
         pc_o               <= '0;
         branch_predicted_o <= 1'b0;
      end else if (flush_i) begin
         instruction_o      <= '0;
         branch_predicted_o <= 1'b0;
      end else if (!stall_i) begin
         if (pop_c) begin
            instruction_o      <= head_c.instr;
            pc_o               <= head_c.pc;
            branch_predicted_o <= head_c.pred;
         end else begin
            instruction_o      <= '0;
            branch_predicted_o <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: vector table, corner sequences, random run vs queue model.
module tb_instruction_fetch_unit;

   localparam int DEPTH = 4;

   logic        clock_i = 1'b0;
   logic        reset_n_i;
   logic        imem_request_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_data_i;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] restart_address_i;
   logic [31:0] instruction_o;
   logic [31:0] pc_o;
   logic        branch_predicted_o;

   instruction_fetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_ADDRESS(32'h0)) dut (
      .clock_i(clock_i), .reset_n_i(reset_n_i),
      .imem_request_o(imem_request_o), .imem_addr_o(imem_addr_o),
      .imem_ack_i(imem_ack_i), .imem_data_i(imem_data_i),
      .stall_i(stall_i), .flush_i(flush_i), .restart_address_i(restart_address_i),
      .instruction_o(instruction_o), .pc_o(pc_o), .branch_predicted_o(branch_predicted_o)
   );

   always #5 clock_i = ~clock_i;

   int tests = 0;
   int fails = 0;

   // memory contents
   logic        special_en   = 1'b0;
   logic [31:0] special_word = 32'h0;
   logic        rand_br      = 1'b0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (special_en && a == 32'h40) return special_word;
      if (rand_br && a[5:2] == 4'hB) return 32'hC000_FFE0;
      return 32'h1000_0000 + (a >> 2);
   endfunction

   // reference model: pending-request flags plus a queue of fetched entries
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        pred;
   } ent_t;

   ent_t        q[$];
   logic        m_req, m_disc, m_pred;
   logic [31:0] m_pc, m_saved, m_instr, m_pco;

   task automatic model_reset();
      q.delete();
      m_req = 0; m_disc = 0; m_pc = 32'h0; m_saved = 32'h0;
      m_instr = 32'h0; m_pco = 32'h0; m_pred = 0;
   endtask

   task automatic model_step(input logic st, input logic fl, input logic [31:0] ra,
                             input logic ak, input logic [31:0] d);
      int          n0;
      bit          pop, push, taken;
      ent_t        e, h;
      logic [31:0] tgt;
      n0    = q.size();
      pop   = !fl && !st && n0 > 0;
      push  = m_req && !m_disc && ak && !fl;
      taken = 0;
`ifdef BRANCH_PREDICT_EN
      taken = (d[31:27] == 5'b11000) && d[15];
`endif
      e.instr = d; e.pc = m_pc + 32'd4; e.pred = taken;
      tgt = taken ? (m_pc + 32'd4 + {{16{d[15]}}, d[15:0]}) : (m_pc + 32'd4);
      if (!m_req) begin
         if (fl) m_pc = ra;
         else if (n0 < DEPTH) m_req = 1;
      end else if (m_disc) begin
         if (fl) m_saved = ra;
         if (ak) begin m_pc = m_saved; m_req = 0; m_disc = 0; end
      end else if (fl) begin
         if (ak) begin m_pc = ra; m_req = 0; end
         else begin m_saved = ra; m_disc = 1; end
      end else if (ak) begin
         m_pc = tgt;
         if (n0 + 1 - int'(pop) >= DEPTH) m_req = 0;
      end
      if (fl) begin
         q.delete(); m_instr = 32'h0; m_pred = 0;
      end else if (!st) begin
         if (n0 > 0) begin
            h = q.pop_front();
            m_instr = h.instr; m_pco = h.pc; m_pred = h.pred;
         end else begin
            m_instr = 32'h0; m_pred = 0;
         end
      end
      if (push) q.push_back(e);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      check("model_req",   32'(imem_request_o),     32'(m_req));
      check("model_addr",  imem_addr_o,             m_pc);
      check("model_instr", instruction_o,           m_instr);
      check("model_pc",    pc_o,                    m_pco);
      check("model_pred",  32'(branch_predicted_o), 32'(m_pred));
   endtask

   // one clock: drive at negedge, step model, check at next negedge
   task automatic tick(input logic st, input logic fl, input logic [31:0] ra, input logic ak);
      stall_i           = st;
      flush_i           = fl;
      restart_address_i = ra;
      imem_ack_i        = ak && m_req;
      imem_data_i       = mem_word(m_pc);
      model_step(st, fl, ra, imem_ack_i, imem_data_i);
      @(posedge clock_i);
      @(negedge clock_i);
      check_model();
   endtask

   task automatic do_reset();
      @(negedge clock_i);
      reset_n_i = 0;
      stall_i = 0; flush_i = 0; restart_address_i = 0; imem_ack_i = 0; imem_data_i = 0;
      model_reset();
      @(negedge clock_i);
      reset_n_i = 1;
   endtask

   typedef struct {
      logic        st;
      logic        ak;
      logic        exp_req;
      logic [31:0] exp_addr;
      logic [31:0] exp_instr;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t        vecs [16];
   logic [31:0] exp_next;
   logic        exp_pred;

   initial begin
      // zero-wait stream, then 5 stall cycles filling the queue, then drain
      vecs[0]  = '{1'b0, 1'b1, 1'b1, 32'h00, 32'h0000_0000, 32'h00};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 32'h04, 32'h0000_0000, 32'h00};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h08, 32'h1000_0000, 32'h04};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 32'h1000_0001, 32'h08};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 32'h10, 32'h1000_0002, 32'h0C};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 32'h14, 32'h1000_0003, 32'h10};
      vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'h18, 32'h1000_0003, 32'h10};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'h1C, 32'h1000_0003, 32'h10};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h20, 32'h1000_0003, 32'h10};
      vecs[9]  = '{1'b1, 1'b1, 1'b0, 32'h20, 32'h1000_0003, 32'h10};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h20, 32'h1000_0003, 32'h10};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h20, 32'h1000_0004, 32'h14};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h20, 32'h1000_0005, 32'h18};
      vecs[13] = '{1'b0, 1'b1, 1'b1, 32'h24, 32'h1000_0006, 32'h1C};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 32'h28, 32'h1000_0007, 32'h20};
      vecs[15] = '{1'b0, 1'b1, 1'b1, 32'h2C, 32'h1000_0008, 32'h24};

      reset_n_i = 0;
      stall_i = 0; flush_i = 0; restart_address_i = 0; imem_ack_i = 0; imem_data_i = 0;
      model_reset();
      repeat (2) @(negedge clock_i);
      check("rst_req",   32'(imem_request_o),     32'h0);
      check("rst_addr",  imem_addr_o,             32'h0);
      check("rst_instr", instruction_o,           32'h0);
      check("rst_pc",    pc_o,                    32'h0);
      check("rst_pred",  32'(branch_predicted_o), 32'h0);
      reset_n_i = 1;

      for (int i = 0; i < 16; i++) begin
         tick(vecs[i].st, 1'b0, 32'h0, vecs[i].ak);
         check($sformatf("vec%0d_req", i),   32'(imem_request_o), 32'(vecs[i].exp_req));
         check($sformatf("vec%0d_addr", i),  imem_addr_o,         vecs[i].exp_addr);
         check($sformatf("vec%0d_instr", i), instruction_o,       vecs[i].exp_instr);
         check($sformatf("vec%0d_pc", i),    pc_o,                vecs[i].exp_pc);
      end

      // flush while the request waits 3 cycles for its ack
      do_reset();
      repeat (3) tick(1'b0, 1'b0, 32'h0, 1'b1);
      tick(1'b0, 1'b1, 32'h200, 1'b0);
      check("fl_instr_nop", instruction_o, 32'h0);
      check("fl_pc_held",   pc_o,          32'h4);
      check("fl_req_held",  32'(imem_request_o), 32'h1);
      check("fl_addr_old",  imem_addr_o,   32'h8);
      repeat (2) tick(1'b0, 1'b0, 32'h0, 1'b0);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("fl_drop_req",  32'(imem_request_o), 32'h0);
      check("fl_drop_nop",  instruction_o, 32'h0);
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      check("fl_new_addr",  imem_addr_o,   32'h200);
      check("fl_new_req",   32'(imem_request_o), 32'h1);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("fl_new_instr", instruction_o, 32'h1000_0080);
      check("fl_new_pc",    pc_o,          32'h204);

      // flush and ack together with three queued entries
      do_reset();
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      repeat (3) tick(1'b1, 1'b0, 32'h0, 1'b1);
      check("fa_pre_addr", imem_addr_o, 32'hC);
      tick(1'b1, 1'b1, 32'h80, 1'b1);
      check("fa_req",   32'(imem_request_o), 32'h0);
      check("fa_addr",  imem_addr_o,   32'h80);
      check("fa_instr", instruction_o, 32'h0);
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      check("fa_empty_nop", instruction_o, 32'h0);
      check("fa_req2",  32'(imem_request_o), 32'h1);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      check("fa_instr2", instruction_o, 32'h1000_0020);
      check("fa_pc2",    pc_o,          32'h84);

      // backward branch at 0x40, then forward branch at 0x40
      do_reset();
      special_en = 1'b1;
      special_word = 32'hC000_FFF8;
`ifdef BRANCH_PREDICT_EN
      exp_next = 32'h3C; exp_pred = 1'b1;
`else
      exp_next = 32'h44; exp_pred = 1'b0;
`endif
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      tick(1'b0, 1'b1, 32'h40, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      check("br_addr40", imem_addr_o, 32'h40);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("br_back_next", imem_addr_o, exp_next);
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      check("br_back_instr", instruction_o, 32'hC000_FFF8);
      check("br_back_pc",    pc_o,          32'h44);
      check("br_back_pred",  32'(branch_predicted_o), 32'(exp_pred));
      tick(1'b0, 1'b1, 32'h40, 1'b0);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      special_word = 32'hC000_0008;
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("br_fwd_next", imem_addr_o, 32'h44);
      tick(1'b0, 1'b0, 32'h0, 1'b0);
      check("br_fwd_instr", instruction_o, 32'hC000_0008);
      check("br_fwd_pred",  32'(branch_predicted_o), 32'h0);
      special_en = 1'b0;

      // asynchronous reset while a request is outstanding
      do_reset();
      repeat (4) tick(1'b0, 1'b0, 32'h0, 1'b1);
      reset_n_i = 0;
      #1;
      check("ar_req",   32'(imem_request_o),     32'h0);
      check("ar_addr",  imem_addr_o,             32'h0);
      check("ar_instr", instruction_o,           32'h0);
      check("ar_pc",    pc_o,                    32'h0);
      check("ar_pred",  32'(branch_predicted_o), 32'h0);
      model_reset();
      imem_ack_i = 0;
      @(negedge clock_i);
      reset_n_i = 1;
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("ar_restart_addr", imem_addr_o, 32'h0);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b1);
      check("ar_first_instr", instruction_o, 32'h1000_0000);

      // randomized traffic against the model
      rand_br = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         tick($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 5,
              32'($urandom_range(255, 0)) << 2, $urandom_range(99, 0) < 55);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
